btb_assoc: RTL and testbench

//  Parametrised N-way set-associative branch target buffer with 2-bit saturating direction counters.

---
 rtl/btb_pkg.sv | 26 ++
 rtl/btb_assoc_if.sv | 42 ++++
 rtl/btb_assoc_set.sv | 74 +++++++
 rtl/btb_assoc.sv | 190 +++++++++++++++++++
 tb/tb_btb_assoc.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/btb_pkg.sv
// Shared definitions for the set-associative branch target buffer:
// jump opcodes, 2-bit direction counter states and saturating helpers.
package btb_pkg;

  localparam logic [3:0] OP_JUMP   = 4'd6;
  localparam logic [3:0] OP_JUMPL  = 4'd7;
  localparam logic [3:0] OP_JUMPG  = 4'd8;
  localparam logic [3:0] OP_JUMPE  = 4'd9;
  localparam logic [3:0] OP_JUMPNE = 4'd10;

  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } ctr_t;

  function automatic ctr_t ctr_inc(input ctr_t c);
    return (c == CTR_ST) ? CTR_ST : ctr_t'(c + 2'd1);
  endfunction

  function automatic ctr_t ctr_dec(input ctr_t c);
    return (c == CTR_SNT) ? CTR_SNT : ctr_t'(c - 2'd1);
  endfunction

endpackage

// File: rtl/btb_assoc_if.sv
// Fetch/EX-facing bus of the branch target buffer; the predictor is the slave,
// the pipeline (or a testbench) is the master.
interface btb_assoc_if #(
  parameter int PC_W   = 16,
  parameter int PERF_W = 32
);
  logic              lookup_valid;
  logic [PC_W-1:0]   fetch_pc;
  logic              flush;
  logic              pred_valid;
  logic              pred_hit;
  logic              pred_taken;
  logic [PC_W-1:0]   pred_target;
  logic              ex_valid;
  logic [PC_W-1:0]   ex_pc;
  logic [3:0]        ex_opcode;
  logic [PC_W-1:0]   ex_target;
  logic              lflag;
  logic              gflag;
  logic              zflag;
  logic              ex_pred_taken;
  logic [PC_W-1:0]   ex_pred_target;
  logic              redirect_valid;
  logic [PC_W-1:0]   redirect_pc;
  logic [PERF_W-1:0] perf_lookups;
  logic [PERF_W-1:0] perf_hits;
  logic [PERF_W-1:0] perf_mispred;

  modport master (
    output lookup_valid, fetch_pc, flush, ex_valid, ex_pc, ex_opcode, ex_target,
           lflag, gflag, zflag, ex_pred_taken, ex_pred_target,
    input  pred_valid, pred_hit, pred_taken, pred_target, redirect_valid, redirect_pc,
           perf_lookups, perf_hits, perf_mispred
  );

  modport slave (
    input  lookup_valid, fetch_pc, flush, ex_valid, ex_pc, ex_opcode, ex_target,
           lflag, gflag, zflag, ex_pred_taken, ex_pred_target,
    output pred_valid, pred_hit, pred_taken, pred_target, redirect_valid, redirect_pc,
           perf_lookups, perf_hits, perf_mispred
  );
endinterface

// File: rtl/btb_assoc_set.sv
// One BTB set: WAYS entries of valid/tag/target/counter, tag compare for the
// lookup and train ports, victim choice and the set's round-robin pointer.
module btb_assoc_set
  import btb_pkg::*;
#(
  parameter int PC_W  = 16,
  parameter int WAYS  = 4,
  parameter int TAG_W = 14,
  parameter int WAY_W = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [TAG_W-1:0]           i_lookupTag,
  input  logic [TAG_W-1:0]           i_trainTag,
  output logic [WAYS-1:0]            o_lookupHit,
  output logic [WAYS-1:0]            o_trainHit,
  output logic [WAYS-1:0][PC_W-1:0]  o_target,
  output ctr_t [WAYS-1:0]            o_ctr,
  output logic [WAY_W-1:0]           o_victim,
  input  logic                       i_wrEn,
  input  logic [WAY_W-1:0]           i_wrWay,
  input  logic                       i_wrValid,
  input  logic [TAG_W-1:0]           i_wrTag,
  input  logic [PC_W-1:0]            i_wrTarget,
  input  ctr_t                       i_wrCtr,
  input  logic                       i_alloc
);

  logic [WAYS-1:0]             r_valid;
  logic [WAYS-1:0][TAG_W-1:0]  r_tag;
  logic [WAYS-1:0][PC_W-1:0]   r_target;
  ctr_t [WAYS-1:0]             r_ctr;
  logic [WAY_W-1:0]            r_rr;
  logic                        w_found;

  for (genvar w = 0; w < WAYS; w++) begin : g_cmp
    assign o_lookupHit[w] = r_valid[w] && (r_tag[w] == i_lookupTag);
    assign o_trainHit[w]  = r_valid[w] && (r_tag[w] == i_trainTag);
  end

  assign o_target = r_target;
  assign o_ctr    = r_ctr;

  // Empty ways are filled lowest-first before the round-robin pointer is used.
  always_comb begin
    o_victim = r_rr;
    w_found  = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!r_valid[w] && !w_found) begin
        o_victim = WAY_W'(w);
        w_found  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid  <= '0;
      r_tag    <= '0;
      r_target <= '0;
      r_rr     <= '0;
      for (int w = 0; w < WAYS; w++) r_ctr[w] <= CTR_SNT;
    end else begin
      if (i_wrEn) begin
        r_valid[i_wrWay]  <= i_wrValid;
        r_tag[i_wrWay]    <= i_wrTag;
        r_target[i_wrWay] <= i_wrTarget;
        r_ctr[i_wrWay]    <= i_wrCtr;
      end
      if (i_alloc) r_rr <= (r_rr == WAY_W'(WAYS - 1)) ? '0 : r_rr + 1'b1;
    end
  end

endmodule

// File: rtl/btb_assoc.sv
// N-way set-associative BTB with 2-bit direction counters and mispredict redirect.
// Define BTB_PERF_EN to build the lookup/hit/mispredict performance counters.
module btb_assoc
  import btb_pkg::*;
#(
  parameter int PC_W    = 16,
  parameter int ENTRIES = 16,
  parameter int WAYS    = 4,
  parameter int PERF_W  = 32
) (
  input logic         clk,
  input logic         rst,
  btb_assoc_if.slave  bus
);

  localparam int SETS     = ENTRIES / WAYS;
  localparam int IDX_BITS = $clog2(SETS);
  localparam int IDX_W    = (IDX_BITS > 0) ? IDX_BITS : 1;
  localparam int TAG_W    = PC_W - IDX_BITS;
  localparam int WAY_W    = (WAYS > 1) ? $clog2(WAYS) : 1;

  logic [WAYS-1:0]            w_lkHitArr [SETS];
  logic [WAYS-1:0]            w_trHitArr [SETS];
  logic [WAYS-1:0][PC_W-1:0]  w_tgtArr   [SETS];
  ctr_t [WAYS-1:0]            w_ctrArr   [SETS];
  logic [WAY_W-1:0]           w_victimArr[SETS];

  logic [IDX_W-1:0] w_lkIdx, w_trIdx;
  logic [TAG_W-1:0] w_lkTag, w_trTag;
  logic             w_accept, w_lkAny, w_lkTaken;
  logic [PC_W-1:0]  w_lkTarget;
  logic [WAYS-1:0]  w_lkHit, w_trHit;
  logic             w_trAny, w_isJump, w_taken;
  logic [WAY_W-1:0] w_trWay;
  logic [PC_W-1:0]  w_trTarget;
  ctr_t             w_trCtr;
  logic             w_wrEn, w_wrValid, w_alloc, w_redirect;
  logic [WAY_W-1:0] w_wrWay;
  logic [PC_W-1:0]  w_wrTarget, w_redirPc;
  ctr_t             w_wrCtr;

  logic             r_predValid, r_predHit, r_predTaken, r_redirValid;
  logic [PC_W-1:0]  r_predTarget, r_redirPc;

  assign w_lkIdx  = (SETS > 1) ? bus.fetch_pc[IDX_W-1:0] : '0;
  assign w_trIdx  = (SETS > 1) ? bus.ex_pc[IDX_W-1:0] : '0;
  assign w_lkTag  = TAG_W'(bus.fetch_pc >> IDX_BITS);
  assign w_trTag  = TAG_W'(bus.ex_pc >> IDX_BITS);
  assign w_accept = bus.lookup_valid && !bus.flush;

  for (genvar s = 0; s < SETS; s++) begin : g_set
    btb_assoc_set #(.PC_W(PC_W), .WAYS(WAYS), .TAG_W(TAG_W), .WAY_W(WAY_W)) u_set (
      .clk         (clk),
      .rst         (rst),
      .i_lookupTag (w_lkTag),
      .i_trainTag  (w_trTag),
      .o_lookupHit (w_lkHitArr[s]),
      .o_trainHit  (w_trHitArr[s]),
      .o_target    (w_tgtArr[s]),
      .o_ctr       (w_ctrArr[s]),
      .o_victim    (w_victimArr[s]),
      .i_wrEn      (w_wrEn && (w_trIdx == IDX_W'(s))),
      .i_wrWay     (w_wrWay),
      .i_wrValid   (w_wrValid),
      .i_wrTag     (w_trTag),
      .i_wrTarget  (w_wrTarget),
      .i_wrCtr     (w_wrCtr),
      .i_alloc     (w_alloc && (w_trIdx == IDX_W'(s)))
    );
  end

  // Read side of both ports sees state before this cycle's training write.
  always_comb begin
    w_lkHit    = w_lkHitArr[w_lkIdx];
    w_trHit    = w_trHitArr[w_trIdx];
    w_lkTarget = '0;
    w_lkTaken  = 1'b0;
    w_trWay    = '0;
    w_trTarget = '0;
    w_trCtr    = CTR_SNT;
    for (int w = 0; w < WAYS; w++) begin
      if (w_lkHit[w]) begin
        w_lkTarget = w_tgtArr[w_lkIdx][w];
        w_lkTaken  = (w_ctrArr[w_lkIdx][w] >= CTR_WT);
      end
      if (w_trHit[w]) begin
        w_trWay    = WAY_W'(w);
        w_trTarget = w_tgtArr[w_trIdx][w];
        w_trCtr    = w_ctrArr[w_trIdx][w];
      end
    end
    w_lkAny = |w_lkHit;
    w_trAny = |w_trHit;
  end

  always_comb begin
    w_isJump = 1'b1;
    w_taken  = 1'b0;
    case (bus.ex_opcode)
      OP_JUMP:   w_taken = 1'b1;
      OP_JUMPL:  w_taken = bus.lflag;
      OP_JUMPG:  w_taken = bus.gflag;
      OP_JUMPE:  w_taken = bus.zflag;
      OP_JUMPNE: w_taken = !bus.zflag;
      default:   w_isJump = 1'b0;
    endcase
  end

  always_comb begin
    w_wrEn     = 1'b0;
    w_wrWay    = w_trWay;
    w_wrValid  = 1'b1;
    w_wrTarget = w_trTarget;
    w_wrCtr    = w_trCtr;
    w_alloc    = 1'b0;
    w_redirect = 1'b0;
    w_redirPc  = bus.ex_pc + PC_W'(1);
    if (bus.ex_valid && w_isJump) begin
      if (w_trAny) begin
        w_wrEn  = 1'b1;
        w_wrCtr = w_taken ? ctr_inc(w_trCtr) : ctr_dec(w_trCtr);
        if (w_taken) w_wrTarget = bus.ex_target;
      end else if (w_taken) begin
        w_wrEn     = 1'b1;
        w_alloc    = 1'b1;
        w_wrWay    = w_victimArr[w_trIdx];
        w_wrTarget = bus.ex_target;
        w_wrCtr    = (bus.ex_opcode == OP_JUMP) ? CTR_ST : CTR_WT;
      end
      w_redirect = (w_taken != bus.ex_pred_taken) ||
                   (w_taken && (bus.ex_target != bus.ex_pred_target));
      if (w_taken) w_redirPc = bus.ex_target;
    end else if (bus.ex_valid && bus.ex_pred_taken) begin
      // A predicted-taken non-jump means the entry is stale: drop it.
      w_redirect = 1'b1;
      w_wrEn     = w_trAny;
      w_wrValid  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_predValid  <= 1'b0;
      r_predHit    <= 1'b0;
      r_predTaken  <= 1'b0;
      r_predTarget <= '0;
      r_redirValid <= 1'b0;
      r_redirPc    <= '0;
    end else begin
      r_predValid  <= w_accept;
      r_predHit    <= w_accept && w_lkAny;
      r_predTaken  <= w_accept && w_lkTaken;
      r_predTarget <= w_accept ? w_lkTarget : '0;
      r_redirValid <= w_redirect;
      r_redirPc    <= w_redirect ? w_redirPc : '0;
    end
  end

  assign bus.pred_valid     = r_predValid;
  assign bus.pred_hit       = r_predHit;
  assign bus.pred_taken     = r_predTaken;
  assign bus.pred_target    = r_predTarget;
  assign bus.redirect_valid = r_redirValid;
  assign bus.redirect_pc    = r_redirPc;

`ifdef BTB_PERF_EN
  logic [PERF_W-1:0] r_perfLookups, r_perfHits, r_perfMispred;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_perfLookups <= '0;
      r_perfHits    <= '0;
      r_perfMispred <= '0;
    end else begin
      if (w_accept && (r_perfLookups != '1)) r_perfLookups <= r_perfLookups + 1'b1;
      if (r_predValid && r_predHit && (r_perfHits != '1)) r_perfHits <= r_perfHits + 1'b1;
      if (r_redirValid && (r_perfMispred != '1)) r_perfMispred <= r_perfMispred + 1'b1;
    end
  end

  assign bus.perf_lookups = r_perfLookups;
  assign bus.perf_hits    = r_perfHits;
  assign bus.perf_mispred = r_perfMispred;
`else
  assign bus.perf_lookups = PERF_W'(0);
  assign bus.perf_hits    = PERF_W'(0);
  assign bus.perf_mispred = PERF_W'(0);
`endif

endmodule

// File: tb/tb_btb_assoc.sv
// Directed bench for btb_assoc: expected responses are queued at issue time and
// a negedge monitor pops and compares them whenever the BTB presents an output.
module tb_btb_assoc;
  import btb_pkg::*;

  logic clk;
  logic rst;
  int   vectors;
  int   misses;
  int   expLookups;
  int   expHits;
  int   expMispred;

  typedef struct {
    logic        hit;
    logic        taken;
    logic [15:0] tgt;
  } predExp_t;

  predExp_t    predQ[$];
  logic [15:0] redirQ[$];

  btb_assoc_if #(.PC_W(16), .PERF_W(32)) bus ();

  btb_assoc #(.PC_W(16), .ENTRIES(16), .WAYS(4), .PERF_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every comparison in the bench funnels through here so the counts stay honest.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      misses++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // One clock of stimulus, driven just after the rising edge.
  task automatic applyStimulus(input logic lkV, input logic [15:0] lkPc, input logic fl,
                               input logic exV, input logic [3:0] op,
                               input logic [15:0] pc, input logic [15:0] tgt,
                               input logic l, input logic g, input logic z,
                               input logic pt, input logic [15:0] ptgt);
    @(posedge clk);
    #1;
    bus.lookup_valid   = lkV;
    bus.fetch_pc       = lkPc;
    bus.flush          = fl;
    bus.ex_valid       = exV;
    bus.ex_opcode      = op;
    bus.ex_pc          = pc;
    bus.ex_target      = tgt;
    bus.lflag          = l;
    bus.gflag          = g;
    bus.zflag          = z;
    bus.ex_pred_taken  = pt;
    bus.ex_pred_target = ptgt;
  endtask

  task automatic idle();
    applyStimulus(0, 16'h0, 0, 0, 4'd0, 16'h0, 16'h0, 0, 0, 0, 0, 16'h0);
  endtask

  task automatic lookup(input logic [15:0] pc);
    applyStimulus(1, pc, 0, 0, 4'd0, 16'h0, 16'h0, 0, 0, 0, 0, 16'h0);
  endtask

  task automatic ex(input logic [3:0] op, input logic [15:0] pc, input logic [15:0] tgt,
                    input logic l, input logic g, input logic z,
                    input logic pt, input logic [15:0] ptgt);
    applyStimulus(0, 16'h0, 0, 1, op, pc, tgt, l, g, z, pt, ptgt);
  endtask

  task automatic expectPred(input logic hit, input logic taken, input logic [15:0] tgt);
    predExp_t e;
    e.hit   = hit;
    e.taken = taken;
    e.tgt   = tgt;
    predQ.push_back(e);
    expLookups++;
    if (hit) expHits++;
  endtask

  task automatic expectRedir(input logic [15:0] pc);
    redirQ.push_back(pc);
    expMispred++;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (bus.pred_valid) begin
        if (predQ.size() == 0) begin
          checkOutput("unexpectedPred", 32'(bus.fetch_pc), 32'hDEAD);
        end else begin
          predExp_t e;
          e = predQ.pop_front();
          checkOutput("predHit", 32'(bus.pred_hit), 32'(e.hit));
          checkOutput("predTaken", 32'(bus.pred_taken), 32'(e.taken));
          checkOutput("predTarget", 32'(bus.pred_target), 32'(e.tgt));
        end
      end
      if (bus.redirect_valid) begin
        if (redirQ.size() == 0) begin
          checkOutput("unexpectedRedirect", 32'(bus.redirect_pc), 32'hDEAD);
        end else begin
          logic [15:0] r;
          r = redirQ.pop_front();
          checkOutput("redirectPc", 32'(bus.redirect_pc), 32'(r));
        end
      end
    end
  end

  initial begin
    vectors    = 0;
    misses     = 0;
    expLookups = 0;
    expHits    = 0;
    expMispred = 0;
    rst = 1'b0;
    bus.lookup_valid = 0; bus.fetch_pc = 0; bus.flush = 0; bus.ex_valid = 0;
    bus.ex_opcode = 0; bus.ex_pc = 0; bus.ex_target = 0; bus.lflag = 0;
    bus.gflag = 0; bus.zflag = 0; bus.ex_pred_taken = 0; bus.ex_pred_target = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("resetPredValid", 32'(bus.pred_valid), 32'd0);
    checkOutput("resetRedirectValid", 32'(bus.redirect_valid), 32'd0);
    rst = 1'b1;

    $display("[TB] cold lookup and first JUMP training");
    lookup(16'h0040);                                       expectPred(0, 0, 16'h0000);
    ex(OP_JUMP, 16'h0040, 16'h0100, 0, 0, 0, 0, 16'h0000);  expectRedir(16'h0100);
    lookup(16'h0040);                                       expectPred(1, 1, 16'h0100);
    ex(OP_JUMP, 16'h0040, 16'h0100, 0, 0, 0, 1, 16'h0100);
    ex(OP_JUMP, 16'h0040, 16'h0200, 0, 0, 0, 1, 16'h0100);  expectRedir(16'h0200);
    lookup(16'h0040);                                       expectPred(1, 1, 16'h0200);

    $display("[TB] not-taken miss at top of address space");
    ex(OP_JUMPNE, 16'hFFFF, 16'h1234, 0, 0, 1, 1, 16'h1234); expectRedir(16'h0000);
    lookup(16'hFFFF);                                        expectPred(0, 0, 16'h0000);
    applyStimulus(1, 16'h0040, 1, 0, 4'd0, 16'h0, 16'h0, 0, 0, 0, 0, 16'h0);

    $display("[TB] JUMPE counter walk at 0x0011");
    ex(OP_JUMPE, 16'h0011, 16'h0222, 0, 0, 1, 0, 16'h0000); expectRedir(16'h0222);
    lookup(16'h0011);                                       expectPred(1, 1, 16'h0222);
    ex(OP_JUMPE, 16'h0011, 16'h0222, 0, 0, 1, 1, 16'h0222);
    lookup(16'h0011);                                       expectPred(1, 1, 16'h0222);
    ex(OP_JUMPE, 16'h0011, 16'h0222, 0, 0, 0, 1, 16'h0222); expectRedir(16'h0012);
    lookup(16'h0011);                                       expectPred(1, 1, 16'h0222);
    ex(OP_JUMPE, 16'h0011, 16'h0222, 0, 0, 0, 1, 16'h0222); expectRedir(16'h0012);
    lookup(16'h0011);                                       expectPred(1, 0, 16'h0222);
    ex(OP_JUMPE, 16'h0011, 16'h0222, 0, 0, 0, 0, 16'h0000);
    lookup(16'h0011);                                       expectPred(1, 0, 16'h0222);
    ex(OP_JUMPE, 16'h0011, 16'h0222, 0, 0, 0, 0, 16'h0000);
    lookup(16'h0011);                                       expectPred(1, 0, 16'h0222);
    ex(OP_JUMPE, 16'h0011, 16'h0222, 0, 0, 1, 0, 16'h0000); expectRedir(16'h0222);
    lookup(16'h0011);                                       expectPred(1, 0, 16'h0222);

    $display("[TB] JUMPL taken / JUMPG not taken");
    ex(OP_JUMPL, 16'h0021, 16'h0300, 1, 0, 0, 0, 16'h0000); expectRedir(16'h0300);
    ex(OP_JUMPG, 16'h0022, 16'h0400, 1, 0, 0, 0, 16'h0000);
    lookup(16'h0021);                                       expectPred(1, 1, 16'h0300);
    lookup(16'h0022);                                       expectPred(0, 0, 16'h0000);

    $display("[TB] fill and overflow set 3");
    ex(OP_JUMP, 16'h0003, 16'h0A00, 0, 0, 0, 0, 16'h0000);  expectRedir(16'h0A00);
    ex(OP_JUMP, 16'h0007, 16'h0A01, 0, 0, 0, 0, 16'h0000);  expectRedir(16'h0A01);
    ex(OP_JUMP, 16'h000B, 16'h0A02, 0, 0, 0, 0, 16'h0000);  expectRedir(16'h0A02);
    ex(OP_JUMP, 16'h000F, 16'h0A03, 0, 0, 0, 0, 16'h0000);  expectRedir(16'h0A03);
    ex(OP_JUMP, 16'h0013, 16'h0A04, 0, 0, 0, 0, 16'h0000);  expectRedir(16'h0A04);
    lookup(16'h0003);                                       expectPred(0, 0, 16'h0000);
    lookup(16'h0007);                                       expectPred(1, 1, 16'h0A01);
    lookup(16'h000F);                                       expectPred(1, 1, 16'h0A03);
    lookup(16'h0013);                                       expectPred(1, 1, 16'h0A04);

    $display("[TB] stale entry invalidation with same-cycle lookup");
    applyStimulus(1, 16'h0040, 0, 1, 4'd0, 16'h0040, 16'h0000, 0, 0, 0, 1, 16'h0200);
    expectPred(1, 1, 16'h0200);
    expectRedir(16'h0041);
    lookup(16'h0040);                                       expectPred(0, 0, 16'h0000);
    repeat (3) idle();
    @(negedge clk);
`ifdef BTB_PERF_EN
    checkOutput("perfLookups", bus.perf_lookups, 32'(expLookups));
    checkOutput("perfHits", bus.perf_hits, 32'(expHits));
    checkOutput("perfMispred", bus.perf_mispred, 32'(expMispred));
`else
    checkOutput("perfLookupsTied", bus.perf_lookups, 32'd0);
    checkOutput("perfHitsTied", bus.perf_hits, 32'd0);
    checkOutput("perfMispredTied", bus.perf_mispred, 32'd0);
`endif

    $display("[TB] reset during lookup and train");
    applyStimulus(1, 16'h0011, 0, 1, OP_JUMP, 16'h0050, 16'h0600, 0, 0, 0, 0, 16'h0000);
    #3;
    rst = 1'b0;
    idle();
    @(negedge clk);
    checkOutput("rstPredValid", 32'(bus.pred_valid), 32'd0);
    checkOutput("rstPredHit", 32'(bus.pred_hit), 32'd0);
    checkOutput("rstPredTarget", 32'(bus.pred_target), 32'd0);
    checkOutput("rstRedirectValid", 32'(bus.redirect_valid), 32'd0);
    checkOutput("rstPerfLookups", bus.perf_lookups, 32'd0);
    checkOutput("rstPerfHits", bus.perf_hits, 32'd0);
    checkOutput("rstPerfMispred", bus.perf_mispred, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    lookup(16'h0011);                                       expectPred(0, 0, 16'h0000);
    lookup(16'h0050);                                       expectPred(0, 0, 16'h0000);
    repeat (3) idle();
    @(negedge clk);
    checkOutput("predQueueDrained", 32'(predQ.size()), 32'd0);
    checkOutput("redirQueueDrained", 32'(redirQ.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
    $finish;
  end

endmodule
